// File: rtl/bp_me_burst_to_lite_mux.sv
// Round-robin multiplexer that reassembles burst BedRock streams (header + data beats)
// from several channels into single full-width lite messages on one memory port.
module bp_me_burst_to_lite_mux #(
   parameter int unsigned num_ch_p         = 2,
   parameter int unsigned header_width_p   = 64,
   parameter int unsigned in_data_width_p  = 64,
   parameter int unsigned out_data_width_p = 512,
   parameter logic [15:0] payload_mask_p   = 16'h0000,
   localparam int unsigned ch_width        = (num_ch_p > 1) ? $clog2(num_ch_p) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic [num_ch_p*header_width_p-1:0]   header_i,
   input  logic [num_ch_p-1:0]                  header_v_i,
   output logic [num_ch_p-1:0]                  header_ready_and_o,
   input  logic [num_ch_p*in_data_width_p-1:0]  data_i,
   input  logic [num_ch_p-1:0]                  data_v_i,
   output logic [num_ch_p-1:0]                  data_ready_and_o,
   output logic [header_width_p-1:0]            mem_header_o,
   output logic [out_data_width_p-1:0]          mem_data_o,
   output logic [ch_width-1:0]                  mem_ch_o,
   output logic                                 mem_v_o,
   input  logic                                 mem_ready_and_i
);

   localparam int unsigned beats     = out_data_width_p / in_data_width_p;
   localparam int unsigned idx_width = (beats > 1) ? $clog2(beats) : 1;
   localparam int unsigned ow_width  = $clog2(out_data_width_p);

   typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_e;

   state_e                                   state;
   logic [header_width_p-1:0]                hdr;
   logic [ch_width-1:0]                      ch;
   logic [ch_width-1:0]                      rr;
   logic [idx_width-1:0]                     idx;
   logic [idx_width-1:0]                     last;
   logic [2:0]                               size;
   logic [beats-1:0][in_data_width_p-1:0]    buffer;
   logic                                     valid;

   logic [num_ch_p-1:0][header_width_p-1:0]  hdr_vec;
   logic [num_ch_p-1:0][in_data_width_p-1:0] data_vec;
   logic [out_data_width_p-1:0]              flat;

   logic [ch_width-1:0]                      grant;
   logic [ch_width-1:0]                      cand;
   logic                                     grant_v;
   logic [header_width_p-1:0]                sel_hdr;
   logic                                     sel_payload;
   int unsigned                              sel_bits;
   logic [idx_width-1:0]                     sel_last;
   int unsigned                              unit;
   logic [ow_width-1:0]                      rep_mask;

   assign hdr_vec  = header_i;
   assign data_vec = data_i;
   assign flat     = buffer;

   assign mem_header_o = hdr;
   assign mem_ch_o     = ch;
   assign mem_v_o      = valid;

   // First requesting channel at or above the round-robin pointer, wrapping.
   always_comb begin
      grant   = '0;
      grant_v = 1'b0;
      cand    = '0;
      for (int unsigned k = 0; k < num_ch_p; k++) begin
         cand = ch_width'((32'(rr) + k) % num_ch_p);
         if (!grant_v && header_v_i[cand]) begin
            grant   = cand;
            grant_v = 1'b1;
         end
      end
   end

   // Beat count of the granted header, stored as the index of its final beat.
   always_comb begin
      sel_hdr     = hdr_vec[grant];
      sel_payload = payload_mask_p[sel_hdr[3:0]];
      sel_bits    = 32'd8 << sel_hdr[6:4];
      if (sel_bits <= in_data_width_p)
         sel_last = '0;
      else if (sel_bits >= out_data_width_p)
         sel_last = idx_width'(beats - 1);
      else
         sel_last = idx_width'(sel_bits / in_data_width_p - 1);
   end

   always_comb begin
      header_ready_and_o = '0;
      if (reset_n_i && state == IDLE && grant_v)
         header_ready_and_o[grant] = 1'b1;
   end

   always_comb begin
      data_ready_and_o = '0;
      if (state == COLLECT)
         data_ready_and_o[ch] = 1'b1;
   end

   // The message occupies (8 << size) bits; that region repeats across the lite word.
   // Data-less messages leave the buffer cleared, so they come out as zero.
   always_comb begin
      unit       = 32'd8 << size;
      rep_mask   = (unit >= out_data_width_p) ? '1 : ow_width'(unit - 1);
      mem_data_o = '0;
      for (int unsigned i = 0; i < out_data_width_p; i++)
         mem_data_o[i] = flat[ow_width'(i) & rep_mask];
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state  <= IDLE;
         hdr    <= '0;
         ch     <= '0;
         rr     <= '0;
         idx    <= '0;
         last   <= '0;
         size   <= '0;
         buffer <= '0;
         valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_v) begin
                  hdr    <= sel_hdr;
                  ch     <= grant;
                  size   <= sel_hdr[6:4];
                  last   <= sel_last;
                  idx    <= '0;
                  buffer <= '0;
                  if (sel_payload) begin
                     state <= COLLECT;
                  end else begin
                     state <= SEND;
                     valid <= 1'b1;
                  end
               end
            end
            COLLECT: begin
               if (data_v_i[ch]) begin
                  buffer[idx] <= data_vec[ch];
                  idx         <= idx + 1'b1;
                  if (idx == last) begin
                     state <= SEND;
                     valid <= 1'b1;
                  end
               end
            end
            SEND: begin
               if (mem_ready_and_i) begin
                  valid <= 1'b0;
                  rr    <= (ch == ch_width'(num_ch_p - 1)) ? '0 : ch + 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   illegal_size: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      (state == IDLE && grant_v) |-> (sel_bits <= out_data_width_p));

endmodule

// File: tb/tb_bp_me_burst_to_lite_mux.sv
// Directed bench for bp_me_burst_to_lite_mux: three channels, msg_type 1 carries data.
module tb_bp_me_burst_to_lite_mux;

   logic          clk;
   logic          reset_n;
   logic [191:0]  header;
   logic [2:0]    header_v;
   logic [2:0]    header_ready;
   logic [191:0]  data;
   logic [2:0]    data_v;
   logic [2:0]    data_ready;
   logic [63:0]   mem_header;
   logic [511:0]  mem_data;
   logic [1:0]    mem_ch;
   logic          mem_v;
   logic          mem_ready;

   int passed = 0;
   int total  = 0;

   bp_me_burst_to_lite_mux #(
      .num_ch_p         (3),
      .header_width_p   (64),
      .in_data_width_p  (64),
      .out_data_width_p (512),
      .payload_mask_p   (16'h0002)
   ) dut (
      .clk_i              (clk),
      .reset_n_i          (reset_n),
      .header_i           (header),
      .header_v_i         (header_v),
      .header_ready_and_o (header_ready),
      .data_i             (data),
      .data_v_i           (data_v),
      .data_ready_and_o   (data_ready),
      .mem_header_o       (mem_header),
      .mem_data_o         (mem_data),
      .mem_ch_o           (mem_ch),
      .mem_v_o            (mem_v),
      .mem_ready_and_i    (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] mk_hdr(input logic [3:0] t, input logic [2:0] s,
                                          input logic [15:0] tag);
      return {40'hA5_5A00_1234, tag, 1'b0, s, t};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n  = 1'b1;
      header   = '0;
      header_v = 3'b111;
      data     = '0;
      data_v   = 3'b111;
      mem_ready = 1'b0;
      #2 reset_n = 1'b0;
      tick(); tick(); #1;
      total++; if (mem_v !== 1'b0) $display("FAIL rst_mem_v: got %b expected 0", mem_v); else passed++;
      total++; if (mem_header !== 64'h0) $display("FAIL rst_header: got %h expected 0", mem_header); else passed++;
      total++; if (mem_data !== 512'h0) $display("FAIL rst_data: got %h expected 0", mem_data); else passed++;
      total++; if (mem_ch !== 2'd0) $display("FAIL rst_ch: got %0d expected 0", mem_ch); else passed++;
      total++; if (header_ready !== 3'b000) $display("FAIL rst_hdr_ready: got %b expected 000", header_ready); else passed++;
      total++; if (data_ready !== 3'b000) $display("FAIL rst_data_ready: got %b expected 000", data_ready); else passed++;
      header_v = '0;
      data_v   = '0;
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_single_write();
      logic [511:0] exp;
      logic [63:0]  h;
      h = mk_hdr(4'd1, 3'd6, 16'h0001);
      for (int k = 0; k < 8; k++) exp[k*64 +: 64] = {8{8'(k)}};
      tick();
      header[0 +: 64] = h;
      header_v = 3'b001;
      #1;
      total++; if (header_ready !== 3'b001) $display("FAIL wr_hdr_ready: got %b expected 001", header_ready); else passed++;
      for (int k = 0; k < 8; k++) begin
         tick();
         header_v = '0;
         data_v   = 3'b001;
         data[0 +: 64] = {8{8'(k)}};
         #1;
         total++; if (data_ready !== 3'b001) $display("FAIL wr_data_ready beat %0d: got %b expected 001", k, data_ready); else passed++;
         total++; if (mem_v !== 1'b0) $display("FAIL wr_early_valid beat %0d: got %b expected 0", k, mem_v); else passed++;
      end
      tick();
      data_v = '0;
      mem_ready = 1'b1;
      #1;
      total++; if (mem_v !== 1'b1) $display("FAIL wr_valid_cycle9: got %b expected 1", mem_v); else passed++;
      total++; if (mem_ch !== 2'd0) $display("FAIL wr_ch: got %0d expected 0", mem_ch); else passed++;
      total++; if (mem_header !== h) $display("FAIL wr_header: got %h expected %h", mem_header, h); else passed++;
      total++; if (mem_data !== exp) $display("FAIL wr_data: got %h expected %h", mem_data, exp); else passed++;
      total++; if (data_ready !== 3'b000) $display("FAIL wr_data_ready_send: got %b expected 000", data_ready); else passed++;
      tick();
      mem_ready = 1'b0;
      #1;
      total++; if (mem_v !== 1'b0) $display("FAIL wr_valid_drop: got %b expected 0", mem_v); else passed++;
   endtask

   task automatic test_read_no_payload();
      logic [63:0] h;
      h = mk_hdr(4'd0, 3'd6, 16'h0002);
      tick();
      header[0 +: 64] = h;
      header_v = 3'b001;
      data_v   = 3'b001;
      #1;
      total++; if (header_ready !== 3'b001) $display("FAIL rd_hdr_ready: got %b expected 001", header_ready); else passed++;
      total++; if (data_ready !== 3'b000) $display("FAIL rd_data_ready_idle: got %b expected 000", data_ready); else passed++;
      tick();
      header_v  = '0;
      mem_ready = 1'b1;
      #1;
      total++; if (mem_v !== 1'b1) $display("FAIL rd_valid_cycle1: got %b expected 1", mem_v); else passed++;
      total++; if (mem_data !== 512'h0) $display("FAIL rd_data_zero: got %h expected 0", mem_data); else passed++;
      total++; if (mem_header !== h) $display("FAIL rd_header: got %h expected %h", mem_header, h); else passed++;
      total++; if (data_ready !== 3'b000) $display("FAIL rd_data_ready_send: got %b expected 000", data_ready); else passed++;
      tick();
      data_v    = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_sub_beat();
      logic [63:0] h;
      h = mk_hdr(4'd1, 3'd2, 16'h0003);
      tick();
      header[128 +: 64] = h;
      header_v = 3'b100;
      #1;
      total++; if (header_ready !== 3'b100) $display("FAIL sub_hdr_ready: got %b expected 100", header_ready); else passed++;
      tick();
      header_v = '0;
      data_v   = 3'b100;
      data[128 +: 64] = 64'hCAFEF00D_DEADBEEF;
      #1;
      total++; if (data_ready !== 3'b100) $display("FAIL sub_data_ready: got %b expected 100", data_ready); else passed++;
      tick();
      data_v    = '0;
      mem_ready = 1'b1;
      #1;
      total++; if (mem_v !== 1'b1) $display("FAIL sub_valid: got %b expected 1", mem_v); else passed++;
      total++; if (mem_ch !== 2'd2) $display("FAIL sub_ch: got %0d expected 2", mem_ch); else passed++;
      total++; if (mem_data !== {16{32'hDEADBEEF}}) $display("FAIL sub_data: got %h expected %h", mem_data, {16{32'hDEADBEEF}}); else passed++;
      tick();
      mem_ready = 1'b0;
   endtask

   task automatic test_fairness();
      logic [63:0] f_hdr [3];
      logic        got;
      for (int c = 0; c < 3; c++) f_hdr[c] = mk_hdr(4'd0, 3'd3, 16'h0100 + 16'(c));
      tick();
      for (int c = 0; c < 3; c++) header[c*64 +: 64] = f_hdr[c];
      header_v  = 3'b111;
      mem_ready = 1'b1;
      for (int m = 0; m < 6; m++) begin
         got = 1'b0;
         for (int c = 0; c < 8 && !got; c++) begin
            tick();
            #1;
            if (mem_v) got = 1'b1;
         end
         total++; if (got !== 1'b1) $display("FAIL fair_timeout msg %0d: got no valid, expected valid within 8 cycles", m); else passed++;
         total++; if (mem_ch !== 2'(m % 3)) $display("FAIL fair_order msg %0d: got ch %0d expected %0d", m, mem_ch, m % 3); else passed++;
         total++; if (mem_header !== f_hdr[m % 3]) $display("FAIL fair_header msg %0d: got %h expected %h", m, mem_header, f_hdr[m % 3]); else passed++;
      end
   endtask

   task automatic test_back_to_back();
      tick();
      header_v = 3'b010;
      header[64 +: 64] = mk_hdr(4'd0, 3'd3, 16'h0B01);
      #1;
      total++; if (header_ready !== 3'b010) $display("FAIL b2b_grant0: got %b expected 010", header_ready); else passed++;
      tick(); #1;
      total++; if (mem_v !== 1'b1 || mem_ch !== 2'd1) $display("FAIL b2b_send0: got v=%b ch=%0d expected v=1 ch=1", mem_v, mem_ch); else passed++;
      total++; if (header_ready !== 3'b000) $display("FAIL b2b_hold_in_send: got %b expected 000", header_ready); else passed++;
      tick(); #1;
      total++; if (header_ready !== 3'b010) $display("FAIL b2b_grant1: got %b expected 010", header_ready); else passed++;
      tick(); #1;
      total++; if (mem_v !== 1'b1 || mem_ch !== 2'd1) $display("FAIL b2b_send1: got v=%b ch=%0d expected v=1 ch=1", mem_v, mem_ch); else passed++;
      tick();
      header_v  = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [63:0] h;
      h = mk_hdr(4'd1, 3'd3, 16'hB0B0);
      tick();
      header[0 +: 64] = h;
      header_v  = 3'b001;
      mem_ready = 1'b0;
      #1;
      total++; if (header_ready !== 3'b001) $display("FAIL bp_hdr_ready: got %b expected 001", header_ready); else passed++;
      tick();
      header_v = '0;
      data_v   = 3'b001;
      data[0 +: 64] = 64'h0123456789ABCDEF;
      #1;
      total++; if (data_ready !== 3'b001) $display("FAIL bp_data_ready: got %b expected 001", data_ready); else passed++;
      tick();
      data_v   = '0;
      header_v = 3'b111;
      #1;
      total++; if (mem_v !== 1'b1) $display("FAIL bp_valid: got %b expected 1", mem_v); else passed++;
      for (int i = 0; i < 5; i++) begin
         tick(); #1;
         total++; if (mem_v !== 1'b1) $display("FAIL bp_stall_valid %0d: got %b expected 1", i, mem_v); else passed++;
         total++; if (mem_header !== h) $display("FAIL bp_stall_header %0d: got %h expected %h", i, mem_header, h); else passed++;
         total++; if (mem_data !== {8{64'h0123456789ABCDEF}}) $display("FAIL bp_stall_data %0d: got %h expected %h", i, mem_data, {8{64'h0123456789ABCDEF}}); else passed++;
         total++; if (header_ready !== 3'b000) $display("FAIL bp_stall_hdr_ready %0d: got %b expected 000", i, header_ready); else passed++;
      end
      tick();
      mem_ready = 1'b1;
      #1;
      total++; if (mem_v !== 1'b1 || header_ready !== 3'b000) $display("FAIL bp_release: got v=%b hr=%b expected v=1 hr=000", mem_v, header_ready); else passed++;
      tick(); #1;
      total++; if (mem_v !== 1'b0) $display("FAIL bp_after_valid: got %b expected 0", mem_v); else passed++;
      total++; if (header_ready !== 3'b010) $display("FAIL bp_next_grant: got %b expected 010", header_ready); else passed++;
      header_v  = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      logic [63:0]  h;
      logic [63:0]  h1;
      logic [511:0] part;
      h  = mk_hdr(4'd1, 3'd6, 16'hA5A5);
      h1 = mk_hdr(4'd1, 3'd3, 16'h1111);
      part = '0;
      for (int k = 0; k < 3; k++) part[k*64 +: 64] = {8{8'(k + 16)}};
      tick();
      header[0 +: 64] = h;
      header_v = 3'b001;
      #1;
      total++; if (header_ready !== 3'b001) $display("FAIL ar_hdr_ready: got %b expected 001", header_ready); else passed++;
      for (int k = 0; k < 3; k++) begin
         tick();
         header_v = '0;
         data_v   = 3'b001;
         data[0 +: 64] = {8{8'(k + 16)}};
         #1;
         total++; if (data_ready !== 3'b001) $display("FAIL ar_data_ready beat %0d: got %b expected 001", k, data_ready); else passed++;
      end
      tick();
      data[0 +: 64] = {8{8'd19}};
      #1;
      total++; if (mem_header !== h) $display("FAIL ar_pre_header: got %h expected %h", mem_header, h); else passed++;
      total++; if (mem_data !== part) $display("FAIL ar_pre_data: got %h expected %h", mem_data, part); else passed++;
      #2 reset_n = 1'b0;
      #1;
      total++; if (mem_v !== 1'b0) $display("FAIL ar_mem_v: got %b expected 0", mem_v); else passed++;
      total++; if (mem_header !== 64'h0) $display("FAIL ar_header: got %h expected 0", mem_header); else passed++;
      total++; if (mem_data !== 512'h0) $display("FAIL ar_data: got %h expected 0", mem_data); else passed++;
      total++; if (mem_ch !== 2'd0) $display("FAIL ar_ch: got %0d expected 0", mem_ch); else passed++;
      total++; if (data_ready !== 3'b000) $display("FAIL ar_data_ready: got %b expected 000", data_ready); else passed++;
      data_v   = '0;
      header_v = 3'b111;
      tick(); #1;
      total++; if (header_ready !== 3'b000) $display("FAIL ar_hdr_ready_in_reset: got %b expected 000", header_ready); else passed++;
      tick();
      reset_n = 1'b1;
      #1;
      total++; if (header_ready !== 3'b001) $display("FAIL ar_rr_restart: got %b expected 001", header_ready); else passed++;
      header[64 +: 64] = h1;
      header_v = 3'b010;
      #1;
      total++; if (header_ready !== 3'b010) $display("FAIL ar_ch1_grant: got %b expected 010", header_ready); else passed++;
      tick();
      header_v = '0;
      data_v   = 3'b010;
      data[64 +: 64] = 64'hFEDCBA9876543210;
      #1;
      total++; if (data_ready !== 3'b010) $display("FAIL ar_ch1_data_ready: got %b expected 010", data_ready); else passed++;
      tick();
      data_v    = '0;
      mem_ready = 1'b1;
      #1;
      total++; if (mem_v !== 1'b1 || mem_ch !== 2'd1) $display("FAIL ar_ch1_send: got v=%b ch=%0d expected v=1 ch=1", mem_v, mem_ch); else passed++;
      total++; if (mem_header !== h1) $display("FAIL ar_ch1_header: got %h expected %h", mem_header, h1); else passed++;
      total++; if (mem_data !== {8{64'hFEDCBA9876543210}}) $display("FAIL ar_ch1_data: got %h expected %h", mem_data, {8{64'hFEDCBA9876543210}}); else passed++;
      tick(); #1;
      total++; if (mem_v !== 1'b0) $display("FAIL ar_ch1_done: got %b expected 0", mem_v); else passed++;
      mem_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_no_payload();
      test_sub_beat();
      test_fairness();
      test_back_to_back();
      test_backpressure();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/bp_me_burst_to_lite_mux.md
# bp_me_burst_to_lite_mux

Multi-channel successor to the single-channel burst-to-lite converter on the tethered memory path. It accepts `num_ch_p` independent burst-format BedRock streams, each a header followed by zero or more data beats. It arbitrates among them round-robin, without interleaving, and reassembles each winning message into one full-width lite message on a single memory command port. It sits between several unicore/accelerator burst sources and the testbench DRAM/host model, and replaces per-source converters plus an external arbiter.

## Interface
Parameters:
- `num_ch_p`, 2: number of burst input channels (≥1).
- `header_width_p`, 64: BedRock mem header width. Header layout:
  - [3:0] msg_type.
  - [6:4] size, log2 bytes, 0..6.
  - Remaining bits are opaque and passed through.
- `in_data_width_p`, 64: burst beat width (power of 2, ≥8).
- `out_data_width_p`, 512: lite data width (power of 2, multiple of `in_data_width_p`).
- `payload_mask_p`, 16'h0000: bit *t* set means msg_type *t* carries data beats.

Ports:
- `clk_i` in 1: clock.
- `reset_n_i` in 1: reset, asynchronous assert, active-low.
- `header_i` in num_ch_p*header_width_p: per-channel headers, channel 0 in the LSBs.
- `header_v_i` in num_ch_p: header valid.
- `header_ready_and_o` out num_ch_p: header ready.
- `data_i` in num_ch_p*in_data_width_p: per-channel beats.
- `data_v_i` in num_ch_p: beat valid.
- `data_ready_and_o` out num_ch_p: beat ready.
- `mem_header_o` out header_width_p: lite header.
- `mem_data_o` out out_data_width_p: lite data.
- `mem_ch_o` out `bsg_safe_clog2(num_ch_p)`: source channel of the current output.
- `mem_v_o` out 1: output valid.
- `mem_ready_and_i` in 1: output ready.

## Operation
- All handshakes are ready-and: a transfer occurs when v & ready are both high in the same cycle.
- Beat count N:
  - N = 0 if `payload_mask_p[msg_type]` = 0.
  - Otherwise N = max(1, (2^size·8)/in_data_width_p).
  - A size whose byte count exceeds out_data_width_p/8 is illegal; a simulation assertion fires.
- FSM states:
  - **IDLE**
    - Grant goes to the first channel with `header_v_i` set, searching from the round-robin pointer `rr` upward with wrap.
    - `header_ready_and_o[grant]` = 1; all other ready bits are 0.
    - On header transfer, latch the header, the channel, and N; clear the beat index.
    - Go to COLLECT if N>0, else go to SEND.
  - **COLLECT**
    - `data_ready_and_o[ch]` = 1 only for the latched channel.
    - Each beat transfer writes beat slot [idx], then idx++.
    - On the transfer of beat N-1, go to SEND.
  - **SEND**
    - `mem_v_o` = 1.
    - On transfer, `rr` ← ch+1 mod num_ch_p; go to IDLE.
- Data assembly:
  - Beat k occupies bits [k·in +: in].
  - If N·in_data_width_p < out_data_width_p, the collected region is replicated to fill `mem_data_o`. This covers sub-beat sizes too: a 4-byte store appears 16 times in 512 bits.
  - Data-less messages drive `mem_data_o` = 0.
- No channel receives any ready while it is not granted. Beats presented before their header are held by the source.
- `mem_header_o` is the latched header, unmodified.

## Timing
- Reset values: `mem_v_o`=0, `mem_header_o`=0, `mem_data_o`=0, `mem_ch_o`=0, all ready outputs=0, `rr`=0, state=IDLE.
- Reset asserts asynchronously and deasserts synchronously to `clk_i`. A reset mid-COLLECT or mid-SEND discards the partial message; no output handshake completes.
- Latency, with the header accepted at cycle 0:
  - Best-case beats arrive in cycles 1..N.
  - `mem_v_o` rises at cycle N+1.
  - A data-less message is valid at cycle 1.
- `mem_v_o` holds stable until `mem_ready_and_i` is sampled. Output registers do not change while `mem_v_o`=1 and `mem_ready_and_i`=0.
- The next header can be accepted in the cycle after the SEND transfer. Peak throughput is one message per N+2 cycles.
- Arbitration uses `header_v_i` only and is combinational in IDLE. A header that arrives the same cycle as the SEND transfer waits one cycle.
- Gaps in `data_v_i` stall COLLECT indefinitely, with no timeout.

## Test plan
- Single channel, num_ch_p=1:
  - Write with size=6 and beats 0x0..0x7, each beat = {8{k}} → one output with data word k at slot k, valid at cycle 9, `mem_ch_o`=0.
  - Read with size=6 and payload bit clear → output at cycle 1, data=0, no `data_ready_and_o` ever asserted.
- Sub-beat replication: write with size=2, data 0xDEADBEEF → N=1; `mem_data_o` = 0xDEADBEEF repeated 16 times.
- Fairness, num_ch_p=3: all channels continuously present reads → output channel order 0,1,2,0,1,2. Channel 1 alone then gets back-to-back grants.
- Backpressure: `mem_ready_and_i`=0 for 5 cycles during SEND → `mem_v_o`, header, and data stay constant; no header accepted on any channel until the transfer.
- Async reset mid-COLLECT after beat 3 of 8 → all outputs are 0 immediately. After release, a fresh message from channel 1 completes normally and `rr` restarts at 0.
